// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage in front of a registered-read register file.
// Optional writeback bypass is enabled by defining ID_WB_BYPASS_EN.
module id_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [REG_AW-1:0] read_reg_num1,
    output logic [REG_AW-1:0] read_reg_num2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [REG_AW-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              regwrite,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] rs1_val,
    output logic [DATA_W-1:0] rs2_val,
    output logic [DATA_W-1:0] imm,
    output logic [REG_AW-1:0] rd,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic              illegal,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid never waits on ready, and bundle outputs
    // hold steady while dec_valid is high and dec_ready is low.
    typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPT, S_OUT} state_t;

    state_t            state, state_n;
    logic [31:0]       ir;
    logic              accept;
    logic [REG_AW-1:0] rs1_idx, rs2_idx;
    logic [31:0]       imm32;
    logic              dec_illegal;
    logic [DATA_W-1:0] op1, op2;

    assign rs1_idx       = ir[15 +: REG_AW];
    assign rs2_idx       = ir[20 +: REG_AW];
    assign read_reg_num1 = rs1_idx;
    assign read_reg_num2 = rs2_idx;
    assign dbg_state     = state;
    assign dec_valid     = (state == S_OUT);
    assign instr_ready   = (state == S_IDLE) || ((state == S_OUT) && dec_ready);
    assign accept        = instr_valid && instr_ready;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (instr_valid) state_n = S_READ;
            S_READ: state_n = S_CAPT;
            S_CAPT: state_n = S_OUT;
            S_OUT:  if (dec_ready) state_n = instr_valid ? S_READ : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Immediate formats; every one sign-extends from instruction bit 31.
    always_comb begin
        imm32       = '0;
        dec_illegal = 1'b0;
        case (ir[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                imm32 = {{20{ir[31]}}, ir[31:20]};
            7'b0100011:
                imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011:
                imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {ir[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            7'b0110011:
                imm32 = '0;
            default:
                dec_illegal = 1'b1;
        endcase
    end

`ifdef ID_WB_BYPASS_EN
    logic              byp1_v, byp2_v;
    logic [DATA_W-1:0] byp1_d, byp2_d;
    logic              wb_hit1, wb_hit2;

    assign wb_hit1 = regwrite && (write_reg != '0) && (write_reg == rs1_idx);
    assign wb_hit2 = regwrite && (write_reg != '0) && (write_reg == rs2_idx);

    // A write seen at the READ edge misses the registered read data, so keep it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp1_v <= 1'b0;
            byp2_v <= 1'b0;
            byp1_d <= '0;
            byp2_d <= '0;
        end else if (state == S_READ) begin
            byp1_v <= wb_hit1;
            byp2_v <= wb_hit2;
            if (wb_hit1) byp1_d <= write_data;
            if (wb_hit2) byp2_d <= write_data;
        end
    end

    assign op1 = wb_hit1 ? write_data : (byp1_v ? byp1_d : read_data1);
    assign op2 = wb_hit2 ? write_data : (byp2_v ? byp2_d : read_data2);
`else
    logic unused_wb;
    assign unused_wb = ^{write_reg, write_data, regwrite};
    assign op1 = read_data1;
    assign op2 = read_data2;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ir      <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
            imm     <= '0;
            rd      <= '0;
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) ir <= instr;
            if (state == S_CAPT) begin
                rs1_val <= (rs1_idx == '0) ? '0 : op1;
                rs2_val <= (rs2_idx == '0) ? '0 : op2;
                imm     <= DATA_W'($signed(imm32));
                rd      <= ir[7 +: REG_AW];
                opcode  <= ir[6:0];
                funct3  <= ir[14:12];
                funct7  <= ir[31:25];
                illegal <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage with a registered-read register file model.
module tb_id_operand_stage;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
  } bundle_t;
  localparam int BW = $bits(bundle_t);

`ifdef ID_WB_BYPASS_EN
  localparam bit BYP_ON = 1'b1;
`else
  localparam bit BYP_ON = 1'b0;
`endif

  logic        clock, reset;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [4:0]  read_reg_num1, read_reg_num2;
  logic [31:0] read_data1, read_data2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regwrite;
  logic        dec_valid, dec_ready;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [4:0]  rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        illegal;
  logic [1:0]  dbg_state;

  id_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd(rd),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // register file: x0 holds junk so the rs==0 forcing is observable
  logic [31:0] regs [32];
  initial begin
    regs[0] = 32'hBAD0_0000;
    for (int i = 1; i < 32; i++) regs[i] = i;
  end
  always @(posedge clock) begin
    read_data1 <= regs[read_reg_num1];
    read_data2 <= regs[read_reg_num2];
  end

  // scoreboard state
  logic [BW-1:0] exp_q[$];
  int            lat_q[$];
  int            total = 0;
  int            bad = 0;
  bit            rand_ready = 0;
  bit            prev_dv = 0;
  bit            prev_xfer = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bundle_t model(input logic [31:0] w, input logic wr_en,
                                    input logic [4:0] wr_reg, input logic [31:0] wr_data);
    bundle_t b;
    logic [4:0] r1, r2;
    r1 = w[19:15];
    r2 = w[24:20];
    b.rs1 = (r1 == 0) ? 32'h0 :
            (BYP_ON && wr_en && wr_reg != 0 && wr_reg == r1) ? wr_data : regs[r1];
    b.rs2 = (r2 == 0) ? 32'h0 :
            (BYP_ON && wr_en && wr_reg != 0 && wr_reg == r2) ? wr_data : regs[r2];
    b.rd  = w[11:7];
    b.op  = w[6:0];
    b.f3  = w[14:12];
    b.f7  = w[31:25];
    b.ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: b.imm = {{20{w[31]}}, w[31:20]};
      7'h23: b.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63: b.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h37, 7'h17: b.imm = {w[31:12], 12'h000};
      7'h6F: b.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      7'h33: b.imm = 32'h0;
      default: begin b.imm = 32'h0; b.ill = 1'b1; end
    endcase
    return b;
  endfunction

  // monitor: compare the head of the queue every cycle the bundle is offered
  always @(negedge clock) begin
    bundle_t e;
    if (reset) begin
      prev_dv = 0;
      prev_xfer = 0;
    end else begin
      if (dec_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bundle", 32'd1, 32'd0);
        end else begin
          e = bundle_t'(exp_q[0]);
          check("rs1_val", rs1_val, e.rs1);
          check("rs2_val", rs2_val, e.rs2);
          check("imm", imm, e.imm);
          check("rd", {27'd0, rd}, {27'd0, e.rd});
          check("opcode", {25'd0, opcode}, {25'd0, e.op});
          check("funct3", {29'd0, funct3}, {29'd0, e.f3});
          check("funct7", {25'd0, funct7}, {25'd0, e.f7});
          check("illegal", {31'd0, illegal}, {31'd0, e.ill});
          check("instr_ready_out", {31'd0, instr_ready}, {31'd0, dec_ready});
          if ((!prev_dv || prev_xfer) && lat_q.size() != 0)
            check("latency", cyc - lat_q.pop_front(), 32'd3);
          if (dec_ready) void'(exp_q.pop_front());
        end
      end
      prev_dv = dec_valid;
      prev_xfer = dec_valid && dec_ready;
    end
  end

  always @(posedge clock) begin
    if (rand_ready) begin
      #2;
      dec_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] w, input logic wr_en, input logic [4:0] wr_reg,
                      input logic [31:0] wr_data, input int wr_cyc,
                      input bit expect_out, input bit chk_in_out);
    int n;
    bundle_t b;
    @(posedge clock); #2;
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (instr_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 32'd1, 32'd0);
        instr_valid = 1'b0;
        return;
      end
    end
    if (chk_in_out) check("accept_in_out", {31'd0, dec_valid}, 32'd1);
    if (expect_out) begin
      b = model(w, wr_en, wr_reg, wr_data);
      exp_q.push_back(BW'(b));
      lat_q.push_back(cyc);
    end
    @(posedge clock); #2;
    instr_valid = 1'b0;
    if (wr_en) begin
      if (wr_cyc == 2) begin @(posedge clock); #2; end
      regwrite = 1'b1;
      write_reg = wr_reg;
      write_data = wr_data;
      @(posedge clock); #2;
      regwrite = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_dec_valid"}, {31'd0, dec_valid}, 32'd0);
    check({tag, "_instr_ready"}, {31'd0, instr_ready}, 32'd1);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    check({tag, "_rrn"}, {22'd0, read_reg_num1, read_reg_num2}, 32'd0);
    check({tag, "_rs1"}, rs1_val, 32'd0);
    check({tag, "_rs2"}, rs2_val, 32'd0);
    check({tag, "_imm"}, imm, 32'd0);
    check({tag, "_fields"}, {rd, opcode, funct3, funct7, illegal}, 32'd0);
  endtask

  logic [6:0] ops [11];

  initial begin
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dec_ready = 1'b1;
    regwrite = 1'b0;
    write_reg = '0;
    write_data = '0;

    @(negedge clock);
    chk_zero("reset");
    @(posedge clock); #2;
    reset = 1'b0;

    // add x3,x1,x2 ; addi x5,x0,-1
    send(32'h002081B3, 0, 0, 0, 0, 1, 0);
    wait_drain(20);
    send(32'hFFF00293, 0, 0, 0, 0, 1, 0);
    wait_drain(20);

    // sw then lui, second accepted while the first is offered
    send(32'h0020A423, 0, 0, 0, 0, 1, 0);
    send(32'h123453B7, 0, 0, 0, 0, 1, 1);
    wait_drain(20);

    // writeback snoop in READ, to x0, and in CAPT on rs2
    send(32'h002081B3, 1, 5'd1, 32'hDEADBEEF, 1, 1, 0);
    wait_drain(20);
    send(32'h002081B3, 1, 5'd0, 32'hDEADBEEF, 1, 1, 0);
    wait_drain(20);
    send(32'h002081B3, 1, 5'd2, 32'hCAFE0002, 2, 1, 0);
    wait_drain(20);

    // downstream stall for 5 cycles, then release
    dec_ready = 1'b0;
    send(32'h00B50533, 0, 0, 0, 0, 1, 0);
    begin
      int n = 0;
      while (!dec_valid && n < 20) begin @(negedge clock); n++; end
      check("stall_reach_out", {31'd0, dec_valid}, 32'd1);
    end
    repeat (5) @(negedge clock);
    check("stall_still_pending", exp_q.size(), 32'd1);
    @(posedge clock); #2;
    dec_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("after_release_idle_valid", {31'd0, dec_valid}, 32'd0);
    check("after_release_idle_state", {30'd0, dbg_state}, 32'd0);
    check("after_release_queue", exp_q.size(), 32'd0);

    // random instructions under random backpressure
    rand_ready = 1;
    for (int i = 0; i < 12; i++) begin
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 10)];
      send(w, 0, 0, 0, 0, 1, 0);
    end
    wait_drain(200);
    rand_ready = 0;
    @(posedge clock); #3;
    dec_ready = 1'b1;

    // illegal opcode, then reset during READ of the next instruction
    send(32'h8000007F, 0, 0, 0, 0, 1, 0);
    wait_drain(20);
    send(32'h002081B3, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk_zero("abort_async");
    @(negedge clock);
    chk_zero("abort");
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("abort_no_bundle", {31'd0, dec_valid}, 32'd0);
    check("abort_queue", exp_q.size() + lat_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
